// File: rtl/atri_clk_pkg.sv
// Shared constants and encodings for the ATRI clock-enable generator.
package atri_clk_pkg;

  localparam int DEF_DIV_WIDTH = 16;

  // Low bit of channel ch inside a packed per-channel bus of width-wide fields.
  function automatic int slice_lo(input int ch, input int width);
    return ch * width;
  endfunction

  typedef enum logic { LK_UNLOCKED = 1'b0, LK_LOCKED   = 1'b1 } lock_e;
  typedef enum logic { CFG_APPLIED = 1'b0, CFG_PENDING = 1'b1 } pend_e;

endpackage

// File: rtl/atri_clkdiv_channel.sv
// One divider channel: period counter, shadow config, registered strobe/level/lock.
module atri_clkdiv_channel
  import atri_clk_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int RESET_DIV = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic                 resync,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic [DIV_WIDTH-1:0] phase_in,
  output logic                 stb,
  output logic                 lvl,
  output logic                 locked,
  output logic                 pending
);

  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   TWO     = (DIV_WIDTH+1)'(2);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, adiv_q, adiv_d, sdiv_q, sdiv_d, sph_q, sph_d;
  logic [DIV_WIDTH:0]   half;
  logic                 at_tc, apply, stb_q, stb_d, lvl_q, lvl_d;
  pend_e                pend_q, pend_d;
  lock_e                lock_q, lock_d;

  // Next-state: config shadow/apply, counter advance, and the output values for the next cycle.
  always_comb begin
    at_tc  = (cnt_q == adiv_q);
    // A pending config swaps in only at a period boundary, while idle, or on resync,
    // so a running channel never sees a truncated period. load+resync bypasses the shadow.
    apply  = ((pend_q == CFG_PENDING) && (at_tc || !en || resync)) || (load && resync);
    sdiv_d = load ? div_in   : sdiv_q;
    sph_d  = load ? phase_in : sph_q;
    adiv_d = adiv_q;
    if (apply) adiv_d = (load && resync) ? div_in : sdiv_q;
    pend_d = pend_q;
    if (load)       pend_d = resync ? CFG_APPLIED : CFG_PENDING;
    else if (apply) pend_d = CFG_APPLIED;

    cnt_d  = cnt_q + ONE;
    stb_d  = 1'b0;
    lock_d = lock_q;
    if (!en) begin
      cnt_d  = '0;
      lock_d = LK_UNLOCKED;
    end else if (resync) begin
      // Phase beyond the period cannot be reached by counting; start from the top instead.
      cnt_d  = (sph_d > adiv_d) ? '0 : sph_d;
      lock_d = LK_UNLOCKED;
    end else if (at_tc) begin
      cnt_d  = '0;
      stb_d  = 1'b1;
      lock_d = apply ? LK_UNLOCKED : LK_LOCKED;
    end

    // One extra bit so div = all-ones does not wrap the half-period threshold.
    half  = ({1'b0, adiv_d} + TWO) >> 1;
    lvl_d = en && ({1'b0, cnt_d} < half);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      adiv_q <= RST_DIV;
      sdiv_q <= RST_DIV;
      sph_q  <= '0;
      pend_q <= CFG_APPLIED;
      lock_q <= LK_UNLOCKED;
      stb_q  <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      adiv_q <= adiv_d;
      sdiv_q <= sdiv_d;
      sph_q  <= sph_d;
      pend_q <= pend_d;
      lock_q <= lock_d;
      stb_q  <= stb_d;
      lvl_q  <= lvl_d;
    end
  end

  assign stb     = stb_q;
  assign lvl     = lvl_q;
  assign locked  = (lock_q == LK_LOCKED);
  assign pending = (pend_q == CFG_PENDING);

endmodule

// File: rtl/atri_clock_enable_generator.sv
// NUM_CH programmable clock-enable timebases on irs_sys_clk with shared load/resync.
module atri_clock_enable_generator
  import atri_clk_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int RESET_DIV = 0
) (
  input  logic                          irs_sys_clk,
  input  logic                          irs_sys_rst_n,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   div_i,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   phase_i,
  input  logic                          load_i,
  input  logic                          resync_i,
  input  logic [NUM_CH-1:0]             ch_en_i,
  output logic [NUM_CH-1:0]             stb_o,
  output logic [NUM_CH-1:0]             lvl_o,
  output logic [NUM_CH-1:0]             locked_o,
  output logic [NUM_CH-1:0]             pending_o
);

  // Channels are independent; load and resync fan out so every channel acts on the same edge.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    atri_clkdiv_channel #(
      .DIV_WIDTH (DIV_WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk      (irs_sys_clk),
      .rst_n    (irs_sys_rst_n),
      .en       (ch_en_i[k]),
      .load     (load_i),
      .resync   (resync_i),
      .div_in   (div_i[slice_lo(k, DIV_WIDTH) +: DIV_WIDTH]),
      .phase_in (phase_i[slice_lo(k, DIV_WIDTH) +: DIV_WIDTH]),
      .stb      (stb_o[k]),
      .lvl      (lvl_o[k]),
      .locked   (locked_o[k]),
      .pending  (pending_o[k])
    );
  end

endmodule

// File: tb/tb_atri_clock_enable_generator.sv
// Bench: directed vector table, hand sequences for corner cases, random run vs a period model.
module tb_atri_clock_enable_generator;

  localparam int NC = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC*DW-1:0]  div_bus = '0, ph_bus = '0;
  logic              ld = 1'b0, rs = 1'b0;
  logic [NC-1:0]     en = '0;
  logic [NC-1:0]     stb, lvl, lck, pnd;

  int n_chk = 0, n_fail = 0;

  atri_clock_enable_generator #(.NUM_CH(NC), .DIV_WIDTH(DW), .RESET_DIV(0)) dut (
    .irs_sys_clk (clk), .irs_sys_rst_n (rst_n),
    .div_i (div_bus), .phase_i (ph_bus), .load_i (ld), .resync_i (rs), .ch_en_i (en),
    .stb_o (stb), .lvl_o (lvl), .locked_o (lck), .pending_o (pnd)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period, divisor in force, shadow config.
  int m_pos[NC], m_div[NC], m_sdiv[NC], m_sph[NC];
  bit m_pend[NC], m_lock[NC], m_stb[NC], m_lvl[NC];

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_pos[k] = 0; m_div[k] = 0; m_sdiv[k] = 0; m_sph[k] = 0;
      m_pend[k] = 0; m_lock[k] = 0; m_stb[k] = 0; m_lvl[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NC; k++) begin
      int d, p;
      bit e, ends, app;
      d = int'(div_bus[k*DW +: DW]);
      p = int'(ph_bus[k*DW +: DW]);
      e = en[k];
      ends = e && !rs && (m_pos[k] == m_div[k]);
      app  = m_pend[k] && ((m_pos[k] == m_div[k]) || !e || rs);
      if (ld && rs) begin
        m_sdiv[k] = d; m_sph[k] = p; m_div[k] = d; m_pend[k] = 0; app = 1;
      end else begin
        if (app) begin m_div[k] = m_sdiv[k]; m_pend[k] = 0; end
        if (ld)  begin m_sdiv[k] = d; m_sph[k] = p; m_pend[k] = 1; end
      end
      if (!e) begin
        m_pos[k] = 0; m_stb[k] = 0; m_lock[k] = 0;
      end else if (rs) begin
        m_pos[k] = (m_sph[k] > m_div[k]) ? 0 : m_sph[k]; m_stb[k] = 0; m_lock[k] = 0;
      end else if (ends) begin
        m_pos[k] = 0; m_stb[k] = 1; m_lock[k] = !app;
      end else begin
        m_pos[k] = m_pos[k] + 1; m_stb[k] = 0;
      end
      // Level is high for the first ceil(period/2) positions.
      m_lvl[k] = e && (2 * m_pos[k] < m_div[k] + 1);
    end
  endtask

  function automatic logic [4*NC-1:0] model_vec();
    logic [NC-1:0] s, v, l, q;
    for (int k = 0; k < NC; k++) begin
      s[k] = m_stb[k]; v[k] = m_lvl[k]; l[k] = m_lock[k]; q[k] = m_pend[k];
    end
    return {s, v, l, q};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, advance one rising edge, compare at the next falling edge.
  task automatic step(input logic l, input logic r, input logic [NC-1:0] e,
                      input logic [NC*DW-1:0] d, input logic [NC*DW-1:0] p);
    ld = l; rs = r; en = e; div_bus = d; ph_bus = p;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("model", 32'({stb, lvl, lck, pnd}), 32'(model_vec()));
    ld = 1'b0; rs = 1'b0;
  endtask

  typedef struct {
    logic ld, rs;
    logic [NC-1:0] en;
    logic [DW-1:0] dv;
    logic [NC-1:0] stb, lvl, lck, pnd;
  } vec_t;

  function automatic vec_t mk(logic l, logic r, logic [NC-1:0] e, logic [DW-1:0] dv,
                              logic [NC-1:0] s, logic [NC-1:0] v, logic [NC-1:0] k, logic [NC-1:0] q);
    vec_t t;
    t.ld = l; t.rs = r; t.en = e; t.dv = dv; t.stb = s; t.lvl = v; t.lck = k; t.pnd = q;
    return t;
  endfunction

  vec_t tbl[22];
  int   first_hit[NC];
  int   exp_hit[NC];
  logic [NC-1:0] cur_en;
  logic [NC*DW-1:0] rd, rp;

  initial begin
    // ch0: div=3 then reprogrammed to 7 mid-period; other channels idle.
    tbl[0]  = mk(1, 0, 4'h0, 16'd3, 4'h0, 4'h0, 4'h0, 4'hF);
    tbl[1]  = mk(0, 1, 4'h1, 16'd3, 4'h0, 4'h1, 4'h0, 4'h0);
    tbl[2]  = mk(0, 0, 4'h1, 16'd3, 4'h0, 4'h1, 4'h0, 4'h0);
    tbl[3]  = mk(0, 0, 4'h1, 16'd3, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[4]  = mk(0, 0, 4'h1, 16'd3, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[5]  = mk(0, 0, 4'h1, 16'd3, 4'h1, 4'h1, 4'h1, 4'h0);
    tbl[6]  = mk(0, 0, 4'h1, 16'd3, 4'h0, 4'h1, 4'h1, 4'h0);
    tbl[7]  = mk(0, 0, 4'h1, 16'd3, 4'h0, 4'h0, 4'h1, 4'h0);
    tbl[8]  = mk(0, 0, 4'h1, 16'd3, 4'h0, 4'h0, 4'h1, 4'h0);
    tbl[9]  = mk(0, 0, 4'h1, 16'd3, 4'h1, 4'h1, 4'h1, 4'h0);
    tbl[10] = mk(1, 0, 4'h1, 16'd7, 4'h0, 4'h1, 4'h1, 4'hF);
    tbl[11] = mk(0, 0, 4'h1, 16'd7, 4'h0, 4'h0, 4'h1, 4'h1);
    tbl[12] = mk(0, 0, 4'h1, 16'd7, 4'h0, 4'h0, 4'h1, 4'h1);
    tbl[13] = mk(0, 0, 4'h1, 16'd7, 4'h1, 4'h1, 4'h0, 4'h0);
    for (int i = 14; i <= 16; i++) tbl[i] = mk(0, 0, 4'h1, 16'd7, 4'h0, 4'h1, 4'h0, 4'h0);
    for (int i = 17; i <= 20; i++) tbl[i] = mk(0, 0, 4'h1, 16'd7, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[21] = mk(0, 0, 4'h1, 16'd7, 4'h1, 4'h1, 4'h1, 4'h0);

    model_reset();
    #3;
    chk("reset_state", 32'({stb, lvl, lck, pnd}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].ld, tbl[i].rs, tbl[i].en, {48'h0, tbl[i].dv}, '0);
      chk($sformatf("tbl_row%0d", i), 32'({stb, lvl, lck, pnd}),
          32'({tbl[i].stb, tbl[i].lvl, tbl[i].lck, tbl[i].pnd}));
    end

    // ch1 div=4 -> level 11100 repeating, strobe every 5; ch2 div=0 -> both constantly high.
    step(1, 1, 4'b0110, 64'h0000_0000_0004_0000, '0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 4'b0110, '0, '0);
      chk($sformatf("div4_div0_c%0d", i), 32'({stb[2:1], lvl[2:1]}),
          32'({1'b1, (i % 5) == 0, 1'b1, (i % 5) < 3}));
    end

    // All channels div=9, phases 0,3,9,12; resync -> first strobes after 10,7,1,10 edges.
    step(1, 0, 4'hF, 64'h0009_0009_0009_0009, 64'h000C_0009_0003_0000);
    step(0, 1, 4'hF, '0, '0);
    chk("resync_lock_clear", 32'(lck), 32'h0);
    for (int k = 0; k < NC; k++) first_hit[k] = 0;
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 4'hF, '0, '0);
      for (int k = 0; k < NC; k++) if (stb[k] && first_hit[k] == 0) first_hit[k] = i;
    end
    exp_hit[0] = 10; exp_hit[1] = 7; exp_hit[2] = 1; exp_hit[3] = 10;
    for (int k = 0; k < NC; k++) chk($sformatf("phase_first_stb_ch%0d", k), first_hit[k], exp_hit[k]);

    // Simultaneous load+resync, div=5: nothing left pending, first strobe 6 edges later.
    step(1, 1, 4'h1, 64'h0005_0005_0005_0005, '0);
    chk("ldrs_pending", 32'(pnd), 32'h0);
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 4'h1, '0, '0);
      chk($sformatf("ldrs_stb_c%0d", i), 32'({stb[0], pnd}), 32'({i == 6, 4'h0}));
    end

    // Disable mid-period for 3 cycles, then re-enable: first strobe div+1 edges later.
    step(0, 0, 4'h1, '0, '0);
    step(0, 0, 4'h1, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'h0, '0, '0);
      chk($sformatf("disabled_c%0d", i), 32'({stb, lvl, lck}), 32'h0);
    end
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 4'h1, '0, '0);
      chk($sformatf("reen_stb_c%0d", i), 32'(stb[0]), 32'(i == 6));
    end

    // Asynchronous reset mid-period clears everything at once, and release emits nothing.
    step(0, 0, 4'h1, '0, '0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({stb, lvl, lck, pnd}), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset_release", 32'({stb, lvl, lck, pnd}), 32'h0);

    // Random traffic against the model, including near-full-scale divisors and a reset.
    cur_en = 4'h1;
    for (int i = 0; i < 1500; i++) begin
      logic l, r;
      if ($urandom_range(0, 15) == 0) cur_en = cur_en ^ (4'b0001 << $urandom_range(0, 3));
      l = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NC; k++) begin
        if ($urandom_range(0, 15) == 0) begin
          rd[k*DW +: DW] = 16'hFFFF - 16'($urandom_range(0, 2));
          rp[k*DW +: DW] = 16'hFFFF - 16'($urandom_range(0, 4));
        end else begin
          rd[k*DW +: DW] = 16'($urandom_range(0, 12));
          rp[k*DW +: DW] = 16'($urandom_range(0, 15));
        end
      end
      step(l, r, cur_en, rd, rp);
      if (i == 700) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_reset", 32'({stb, lvl, lck, pnd}), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/atri_clock_enable_generator.md
Name: atri_clock_enable_generator

Overview:
- Parametrised successor to the ATRI refclk/BUFG clock generator.
- Runs entirely on irs_sys_clk and derives NUM_CH programmable divided timebases for IRS sampling, trigger and housekeeping logic.
- Each timebase is delivered as a single-cycle strobe plus a ~50% clock-enable level, not as new clock nets.
- Supports glitch-free divisor/phase reprogramming, a global phase resync and per-channel lock indication.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
DIV_WIDTH, 16, width of divisor and phase fields
RESET_DIV, 0, divisor loaded into every shadow/active register at reset

Ports:
irs_sys_clk  input  1  system clock; all logic on its rising edge
irs_sys_rst_n  input  1  reset, asynchronous assert, active-low
div_i  input  NUM_CH*DIV_WIDTH  per-channel divisor; period = div+1 cycles; ch k at [k*DIV_WIDTH +: DIV_WIDTH]
phase_i  input  NUM_CH*DIV_WIDTH  per-channel counter preload applied on resync
load_i  input  1  one-cycle pulse; captures div_i/phase_i into shadow registers
resync_i  input  1  one-cycle pulse; restarts all enabled channels at their phase
ch_en_i  input  NUM_CH  per-channel enable
stb_o  output  NUM_CH  one-cycle strobe, once per period
lvl_o  output  NUM_CH  clock-enable level, high for the first ceil((div+1)/2) cycles of each period
locked_o  output  NUM_CH  channel running with its current configuration for at least one full period
pending_o  output  NUM_CH  shadow configuration captured but not yet applied

Behaviour:
- Reset (async, irs_sys_rst_n=0): cnt=0, active_div=shadow_div=RESET_DIV, shadow_phase=0; stb_o, lvl_o, locked_o, pending_o all 0.
- Per-channel state: cnt[DIV_WIDTH], active_div, shadow_div, shadow_phase, pending.
- load_i: shadow <= div_i/phase_i slice; pending <= 1 for every channel.
- Apply point: at any edge where pending=1, and either cnt==active_div, ch_en=0, or resync_i=1:
  - active_div <= shadow_div; pending <= 0; locked <= 0.
- Terminal count (ch_en=1, cnt==active_div, no resync): cnt <= 0; stb_o <= 1.
- Otherwise when enabled: cnt <= cnt+1; stb_o <= 0.
- All outputs are registered. stb_o is visible during the cycle in which cnt==0.
- lvl_o is registered from the next cnt value: lvl_o <= (next_cnt < (div_eff+2)>>1), where div_eff is the divisor in force after the edge. Compute with DIV_WIDTH+1 bits; no overflow at div = all-ones.
- div=0: stb_o and lvl_o are constantly 1 while enabled.
- resync_i with ch_en=1:
  - cnt <= shadow_phase if pending, else the phase captured at the last load.
  - Phase > div_eff is clamped: cnt <= 0.
  - stb_o <= 0; locked <= 0.
  - All channels resync on the same edge.
- load_i and resync_i on the same cycle: new div_i/phase_i are captured and applied immediately on that edge; pending ends 0.
- ch_en=0: cnt held 0; stb_o, lvl_o, locked_o = 0. Pending shadow is applied on the first disabled cycle.
- Enable rising: counting starts from cnt=0 on the next edge, so the first stb_o occurs div+1 cycles after enable.
- locked_o: set on the edge producing the first terminal-count stb_o after reset, resync, enable or config apply. Cleared on resync, disable or apply.
- Reset mid-operation: everything returns to reset values asynchronously. No strobe is emitted during or on release.

Decomposition:
- Package atri_clk_pkg holds:
  - DIV_WIDTH default
  - Slice helper constants for the packed div/phase buses
  - Lock/pending encoding
- One sub-module, atri_clkdiv_channel, implements the per-channel counter, shadow registers and output regs.
- Top level instantiates NUM_CH channels and fans out load_i/resync_i.

Test Plan:
- Reset release, ch_en=0001, load div=3 phase=0, resync at edge 0 -> stb_o[0] high in cycles 4,8,12; lvl_o[0] high cycles 0-1, 4-5; locked_o[0] rises at cycle 4.
- div=4 on ch1, div=0 on ch2 -> ch1 lvl_o pattern 11100 repeating with stb every 5 cycles; ch2 stb_o and lvl_o constant 1.
- Ch0 running div=3, load div=7 mid-period (cnt=1) -> pending_o[0]=1 until next terminal count; following periods are 8 cycles; no short or runt period.
- Channels 0..3 div=9 with phases 0,3,9,12, then resync -> strobes at offsets 10,7,1,10 cycles (phase 12 clamped to 0); all locked_o clear on resync.
- Simultaneous load_i+resync_i with div=5 -> first stb 6 cycles later; pending_o stays 0.
- Drop ch_en mid-period, re-enable after 3 cycles -> outputs 0 while disabled, first stb div+1 cycles after re-enable. Assert irs_sys_rst_n low mid-period -> all outputs 0 immediately.
